// File: rtl/txshift_frame_if.sv
// rtl/txshift_frame_if.sv - handshake and serial-line bundle between the Tx data register and the serialiser
interface txshift_frame_if;
    logic       i_Enable;
    logic       i_Busy;
    logic [7:0] i_Data;
    logic       o_Txd;
    logic       o_Sclk;
    logic       o_Active;
    logic       o_Done;

    modport master (
        output i_Enable, i_Busy, i_Data,
        input  o_Txd, o_Sclk, o_Active, o_Done
    );

    modport slave (
        input  i_Enable, i_Busy, i_Data,
        output o_Txd, o_Sclk, o_Active, o_Done
    );
endinterface

// File: rtl/txshift_frame.sv
// rtl/txshift_frame.sv - USRT transmit serialiser: start, LSB-first data, optional parity, stop bits, with Sclk
module txshift_frame #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            i_Pclk,
    input  logic            i_Reset_n,
    txshift_frame_if.slave  bus
);
    localparam int CNT_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [2:0]             bit_idx_q;
    logic                   stop_idx_q;
    logic                   par_q;
    logic                   txd_q;
    logic                   sclk_q;
    logic                   active_q;
    logic                   done_q;
    logic                   bit_end;
    logic                   in_bit;

    assign cnt_d   = cnt_q + 1'b1;
    assign bit_end = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign in_bit  = (state_q == S_START) || (state_q == S_DATA) ||
                     (state_q == S_PARITY) || (state_q == S_STOP);

    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            sclk_q     <= 1'b1;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Sclk falls at each bit boundary, so Txd is stable across the rising edge
            if (in_bit) begin
                if (bit_end) begin
                    cnt_q  <= '0;
                    sclk_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    sclk_q <= (cnt_d >= CNT_W'(CLK_DIV / 2));
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.i_Enable && bus.i_Busy) begin
                        shift_q  <= bus.i_Data[DATA_BITS-1:0];
                        par_q    <= (^bus.i_Data[DATA_BITS-1:0]) ^ 1'(PARITY_ODD);
                        state_q  <= S_START;
                        cnt_q    <= '0;
                        txd_q    <= 1'b0;
                        sclk_q   <= 1'b0;
                        active_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state_q   <= S_DATA;
                        txd_q     <= shift_q[0];
                        bit_idx_q <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                            if (PARITY_EN != 0) begin
                                state_q <= S_PARITY;
                                txd_q   <= par_q;
                            end else begin
                                state_q    <= S_STOP;
                                txd_q      <= 1'b1;
                                stop_idx_q <= 1'b0;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state_q    <= S_STOP;
                        txd_q      <= 1'b1;
                        stop_idx_q <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                            state_q  <= S_WAIT;
                            done_q   <= 1'b1;
                            active_q <= 1'b0;
                            sclk_q   <= 1'b1;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // hold off until the register clears busy so the same byte is not resent
                    if (!bus.i_Busy) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.o_Txd    = txd_q;
    assign bus.o_Sclk   = sclk_q;
    assign bus.o_Active = active_q;
    assign bus.o_Done   = done_q;
endmodule

// File: tb/tb_txshift_frame.sv
// tb/tb_txshift_frame.sv - directed checks of txshift_frame in 8N1, 8E1, 8O1 and 7N2 configurations
module tb_txshift_frame;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, busy;
    logic [7:0] data;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    txshift_frame_if if0 ();
    txshift_frame_if if1 ();
    txshift_frame_if if2 ();
    txshift_frame_if if3 ();
    assign if0.i_Enable = en; assign if0.i_Busy = busy; assign if0.i_Data = data;
    assign if1.i_Enable = en; assign if1.i_Busy = busy; assign if1.i_Data = data;
    assign if2.i_Enable = en; assign if2.i_Busy = busy; assign if2.i_Data = data;
    assign if3.i_Enable = en; assign if3.i_Busy = busy; assign if3.i_Data = data;

    txshift_frame #(.DATA_BITS(8), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        d0 (.i_Pclk(clk), .i_Reset_n(rst_n), .bus(if0));
    txshift_frame #(.DATA_BITS(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        d1 (.i_Pclk(clk), .i_Reset_n(rst_n), .bus(if1));
    txshift_frame #(.DATA_BITS(8), .CLK_DIV(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        d2 (.i_Pclk(clk), .i_Reset_n(rst_n), .bus(if2));
    txshift_frame #(.DATA_BITS(7), .CLK_DIV(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        d3 (.i_Pclk(clk), .i_Reset_n(rst_n), .bus(if3));

    logic [3:0] txd_w, sclk_w, act_w, done_w;
    assign txd_w  = {if3.o_Txd,    if2.o_Txd,    if1.o_Txd,    if0.o_Txd};
    assign sclk_w = {if3.o_Sclk,   if2.o_Sclk,   if1.o_Sclk,   if0.o_Sclk};
    assign act_w  = {if3.o_Active, if2.o_Active, if1.o_Active, if0.o_Active};
    assign done_w = {if3.o_Done,   if2.o_Done,   if1.o_Done,   if0.o_Done};

    typedef struct {
        logic [7:0] data;
        logic       par_even;
    } vec_t;

    int cfg_nd   [4] = '{8, 8, 8, 7};
    int cfg_pen  [4] = '{0, 1, 1, 0};
    int cfg_podd [4] = '{0, 0, 1, 0};
    int cfg_nstop[4] = '{1, 1, 1, 2};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Loads one byte, captures 48 cycles of every DUT and compares against the framed bit pattern.
    task automatic run_frame(input vec_t v);
        logic [47:0] ctx [4];
        logic [47:0] csc [4];
        logic [47:0] cdn [4];
        logic [47:0] etx, esc, edn;
        logic [15:0] bits;
        int          nb;
        @(negedge clk);
        data = v.data; en = 1'b1; busy = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                ctx[k][i] = txd_w[k]; csc[k][i] = sclk_w[k]; cdn[k][i] = done_w[k];
            end
            if (i == 2) busy = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            bits = '1;
            bits[0] = 1'b0;
            for (int b = 0; b < cfg_nd[k]; b++) bits[1+b] = v.data[b];
            if (cfg_pen[k] != 0) bits[1+cfg_nd[k]] = v.par_even ^ cfg_podd[k][0];
            nb = 1 + cfg_nd[k] + cfg_pen[k] + cfg_nstop[k];
            for (int i = 0; i < 48; i++) begin
                etx[i] = (i < nb*4) ? bits[i/4] : 1'b1;
                esc[i] = (i < nb*4) ? ((i % 4) >= 2) : 1'b1;
                edn[i] = (i == nb*4);
            end
            chk($sformatf("txd d%0d data=%h", k, v.data),  64'(ctx[k]), 64'(etx));
            chk($sformatf("sclk d%0d data=%h", k, v.data), 64'(csc[k]), 64'(esc));
            chk($sformatf("done d%0d data=%h", k, v.data), 64'(cdn[k]), 64'(edn));
        end
        repeat (4) @(negedge clk);
    endtask

    vec_t vecs[6];
    int   done_at;
    logic [2:0]  bits3;
    logic        bad;

    initial begin
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h3C, 1'b0};
        vecs[2] = '{8'h01, 1'b1};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h7F, 1'b1};

        rst_n = 1'b0; en = 1'b0; busy = 1'b0; data = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset txd",    64'(txd_w),  64'hF);
        chk("reset sclk",   64'(sclk_w), 64'hF);
        chk("reset active", 64'(act_w),  64'h0);
        chk("reset done",   64'(done_w), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 6; n++) run_frame(vecs[n]);

        // Busy held after done: stay in WAIT, no resend
        data = 8'hA5; en = 1'b1; busy = 1'b1;
        @(posedge clk);
        done_at = -1;
        for (int i = 0; i < 60 && done_at < 0; i++) begin
            @(negedge clk);
            if (if0.o_Done) done_at = i;
        end
        chk("wait done latency", 64'(done_at), 64'd40);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if0.o_Txd !== 1'b1 || if0.o_Active !== 1'b0 || if0.o_Done !== 1'b0) bad = 1'b1;
        end
        chk("wait holds idle", 64'(bad), 64'd0);
        busy = 1'b0;
        repeat (2) @(negedge clk);
        data = 8'h3C; busy = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (i == 4)  bits3[2] = if0.o_Txd;
            if (i == 8)  bits3[1] = if0.o_Txd;
            if (i == 12) bits3[0] = if0.o_Txd;
            if (i == 2) busy = 1'b0;
        end
        chk("reload 0x3C bits 0..2", 64'(bits3), 64'b001);

        // Reset mid-frame at cycle 17 of a 0xFF frame
        @(negedge clk);
        data = 8'hFF; en = 1'b1; busy = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= 17; i++) @(negedge clk);
        busy = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort txd",    64'(txd_w),  64'hF);
        chk("abort sclk",   64'(sclk_w), 64'hF);
        chk("abort active", 64'(act_w),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done_w !== 4'h0) bad = 1'b1;
        end
        chk("abort no done", 64'(bad), 64'd0);
        run_frame(vecs[3]);

        // Enable low blocks loads; dropping it mid-frame lets the frame finish
        en = 1'b0; busy = 1'b1; data = 8'h55;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (txd_w !== 4'hF || act_w !== 4'h0) bad = 1'b1;
        end
        chk("disabled stays idle", 64'(bad), 64'd0);
        en = 1'b1;
        @(posedge clk);
        done_at = -1;
        bits3 = '0;
        for (int i = 0; i < 60 && done_at < 0; i++) begin
            @(negedge clk);
            if (i == 3) en = 1'b0;
            if (i == 4) bits3[0] = if0.o_Txd;
            if (if0.o_Done) done_at = i;
        end
        chk("enable drop done latency", 64'(done_at), 64'd40);
        chk("enable drop bit0", 64'(bits3), 64'b001);
        busy = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
